// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential arithmetic blocks (multiplier now, divider later).
package mult_pkg;

   localparam int DEFAULT_WIDTH = 32;
   // Widest operand abs_val can take; callers zero-extend narrower operands.
   localparam int ABS_MAX_W     = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Caller passes neg = signed_mode & operand MSB; the low WIDTH bits of the result are the magnitude.
   function automatic logic [ABS_MAX_W-1:0] abs_val(input logic [ABS_MAX_W-1:0] x,
                                                    input logic                 neg);
      return neg ? -x : x;
   endfunction

endpackage

// File: rtl/mult_seq_dp.sv
// Shift-add datapath: operand capture as magnitudes, one accumulate/shift per step,
// and sign fix-up of the final product.
module mult_seq_dp
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               step,
   input  logic               finish,
   input  logic               in_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] product
);

   localparam int AW = 2*WIDTH + 1;

   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic               neg_q, neg_d;
   logic [AW-1:0]      acc_q, acc_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic [WIDTH:0]     upper_sum;
   logic [AW-1:0]      acc_step;

   function automatic logic signed [2*WIDTH-1:0] sign_fix(input logic [2*WIDTH-1:0] mag,
                                                          input logic               neg);
      logic signed [2*WIDTH-1:0] mag_s;
      mag_s = signed'(mag);
      return neg ? -mag_s : mag_s;
   endfunction

   always_comb begin
      mcand_d   = mcand_q;
      neg_d     = neg_q;
      acc_d     = acc_q;
      product_d = product_q;
      // Upper half carries one spare bit so the add never overflows before the shift.
      upper_sum = acc_q[AW-1:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : '0);
      acc_step  = {1'b0, upper_sum, acc_q[WIDTH-1:1]};

      if (load) begin
         mcand_d = WIDTH'(abs_val(ABS_MAX_W'(a), in_signed & a[WIDTH-1]));
         neg_d   = in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
         acc_d   = {{(WIDTH+1){1'b0}},
                    WIDTH'(abs_val(ABS_MAX_W'(b), in_signed & b[WIDTH-1]))};
      end else if (step) begin
         acc_d = acc_step;
         if (finish) begin
            product_d = sign_fix(acc_step[2*WIDTH-1:0], neg_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         product_q <= '0;
      end else begin
         product_q <= product_d;
      end
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
   end

   assign product = product_q;

endmodule

// File: rtl/mult_seq.sv
// Multi-cycle signed/unsigned shift-add multiplier with valid/ready handshakes;
// one multiply in flight, WIDTH cycles from accept to result.
module mult_seq
   import mult_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CNT_W = $clog2(WIDTH+1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load, step, finish;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      load      = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            busy  = 1'b1;
            step  = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            // Last iteration: the datapath writes the product on this same edge.
            if (cnt_q == CNT_W'(WIDTH-1)) begin
               finish  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   mult_seq_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .step      (step),
      .finish    (finish),
      .in_signed (in_signed),
      .a         (a),
      .b         (b),
      .product   (product)
   );

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: three widths (8, 16, 32) run side by side, each with
// its own driver, consumer/monitor and arithmetic reference model.
`timescale 1ns/1ps
module tb_mult_seq;

   typedef struct {
      logic [127:0] exp;
      int           acc_cyc;
      int           stall;
   } sb_entry_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input int w, input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL W%0d %s: got %0h, expected %0h (cycle %0d)", w, nm, act, exp, cyc);
      end
   endtask

   task automatic bound_expired(input int w, input string nm);
      n_cmp++;
      n_fail++;
      $display("FAIL W%0d %s: wait bound expired (cycle %0d)", w, nm, cyc);
   endtask

   for (genvar gi = 0; gi < 3; gi++) begin : g_w
      localparam int W = (gi == 0) ? 8 : (gi == 1) ? 16 : 32;

      logic           rst, in_valid, in_ready, in_signed, out_valid, out_ready, busy;
      logic [W-1:0]   a, b;
      logic [2*W-1:0] product;
      sb_entry_t      sb[$];
      logic           in_txn;
      bit             fin = 1'b0;

      mult_seq #(.WIDTH(W)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .in_signed (in_signed),
         .a         (a),
         .b         (b),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .product   (product),
         .busy      (busy)
      );

      // Mathematical product modulo 2^(2W) of the operands read as signed or unsigned numbers.
      function automatic logic [127:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic s);
         logic signed [2*W-1:0] xs, ys;
         logic [2*W-1:0]        p;
         xs = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
         ys = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
         p  = xs * ys;
         return 128'(p);
      endfunction

      function automatic logic [W-1:0] pick();
         case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
         endcase
      endfunction

      task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                           input logic [127:0] e, input int st);
         int t;
         t = 0;
         while (!in_ready && t < 300) begin
            @(posedge clk); #1; t++;
         end
         if (!in_ready) begin
            bound_expired(W, "accept");
            return;
         end
         in_valid  = 1'b1;
         a         = x;
         b         = y;
         in_signed = s;
         @(posedge clk); #1;
         sb.push_back('{e, cyc, st});
         t = 0;
         // Junk on the inputs while not idle must be ignored.
         while (!in_ready && t < 300) begin
            in_valid  = 1'($urandom);
            a         = W'($urandom);
            b         = W'($urandom);
            in_signed = 1'($urandom);
            @(posedge clk); #1; t++;
         end
         in_valid = 1'b0;
         if (!in_ready) bound_expired(W, "return_to_idle");
      endtask

      initial begin : driver
         logic [W-1:0] mn, mx, x, y;
         logic         s;
         int           t;
         mn = {1'b1, {(W-1){1'b0}}};
         mx = {1'b0, {(W-1){1'b1}}};
         rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; a = '0; b = '0;
         repeat (3) @(posedge clk);
         #1;
         chk(W, "reset in_ready", 128'(in_ready), 128'd1);
         chk(W, "reset out_valid", 128'(out_valid), 128'd0);
         chk(W, "reset busy", 128'(busy), 128'd0);
         chk(W, "reset product", 128'(product), 128'd0);
         rst = 1'b0;

         if (W == 32) begin
            issue(W'(32'hFFFF_FFFF), W'(32'hFFFF_FFFF), 1'b0, 128'hFFFF_FFFE_0000_0001, 0);
            issue(W'(-3), W'(7), 1'b1, 128'hFFFF_FFFF_FFFF_FFEB, 2);
            issue(W'(-3), W'(7), 1'b0, 128'h0000_0006_FFFF_FFEB, 0);
         end else if (W == 8) begin
            issue(W'(8'h80), W'(8'h80), 1'b1, 128'h4000, 0);
            issue(W'(8'h80), W'(8'h7F), 1'b1, 128'hC080, 1);
         end else begin
            issue('1, '1, 1'b0, ref_mul('1, '1, 1'b0), 0);
            issue(W'(-3), W'(7), 1'b1, ref_mul(W'(-3), W'(7), 1'b1), 0);
         end
         issue(mn, mn, 1'b1, ref_mul(mn, mn, 1'b1), 10);
         issue('0, mx, 1'b0, ref_mul('0, mx, 1'b0), 0);
         issue(mn, mx, 1'b1, ref_mul(mn, mx, 1'b1), 3);

         // Abort an operation part-way through, then check a clean restart.
         in_valid = 1'b1; a = W'($urandom); b = W'($urandom); in_signed = 1'b0;
         @(posedge clk); #1;
         in_valid = 1'b0;
         repeat (5) begin @(posedge clk); #1; end
         chk(W, "mid busy", 128'(busy), 128'd1);
         chk(W, "mid in_ready", 128'(in_ready), 128'd0);
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         chk(W, "abort in_ready", 128'(in_ready), 128'd1);
         chk(W, "abort out_valid", 128'(out_valid), 128'd0);
         chk(W, "abort busy", 128'(busy), 128'd0);
         chk(W, "abort product", 128'(product), 128'd0);
         issue(W'(3), W'(5), 1'b0, 128'd15, 0);

         for (int i = 0; i < 600; i++) begin
            x = pick();
            y = pick();
            s = 1'($urandom);
            issue(x, y, s, ref_mul(x, y, s),
                  ($urandom_range(0, 15) == 0) ? 10 : int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end

         t = 0;
         while ((sb.size() != 0 || in_txn) && t < 2000) begin
            @(posedge clk); #1; t++;
         end
         if (sb.size() != 0 || in_txn) bound_expired(W, "drain");
         fin = 1'b1;
      end

      initial begin : monitor
         logic [2*W-1:0] held;
         int             stall_left;
         logic           releasing;
         sb_entry_t      e;
         in_txn     = 1'b0;
         out_ready  = 1'b0;
         releasing  = 1'b0;
         held       = '0;
         stall_left = 0;
         forever begin
            @(negedge clk);
            if (releasing) begin
               releasing = 1'b0;
               chk(W, "release out_valid", 128'(out_valid), 128'd0);
               chk(W, "release in_ready", 128'(in_ready), 128'd1);
               chk(W, "release product hold", 128'(product), 128'(held));
            end
            if (out_valid) begin
               if (!in_txn) begin
                  in_txn = 1'b1;
                  held   = product;
                  if (sb.size() == 0) begin
                     n_cmp++;
                     n_fail++;
                     $display("FAIL W%0d unexpected output: product %0h with nothing outstanding", W, product);
                     stall_left = 0;
                  end else begin
                     e = sb.pop_front();
                     chk(W, "product", 128'(product), e.exp);
                     chk(W, "latency", 128'(cyc - e.acc_cyc), 128'(W));
                     chk(W, "done in_ready", 128'(in_ready), 128'd0);
                     stall_left = e.stall;
                  end
               end else begin
                  chk(W, "stall product", 128'(product), 128'(held));
                  chk(W, "stall in_ready", 128'(in_ready), 128'd0);
               end
               if (stall_left > 0) begin
                  out_ready = 1'b0;
                  stall_left--;
               end else begin
                  out_ready = 1'b1;
                  releasing = 1'b1;
                  in_txn    = 1'b0;
               end
            end else begin
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      end
   end

   initial begin : main
      int t;
      t = 0;
      while (!(g_w[0].fin && g_w[1].fin && g_w[2].fin) && t < 90000) begin
         @(posedge clk); t++;
      end
      if (!(g_w[0].fin && g_w[1].fin && g_w[2].fin)) begin
         n_cmp++;
         n_fail++;
         $display("FAIL run timeout: drivers unfinished after %0d cycles", t);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Parametrised, multi-cycle shift-add multiplier; successor to the combinational 32x32 multiplier.
- Generalised in operand width; adds a signed/unsigned mode and valid/ready handshakes on input and output.
- Sits in arithmetic datapaths where area matters more than latency; one multiply in flight at a time.

Parameters:
- WIDTH, 32, operand width in bits (>=2); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  result; signed or unsigned per the captured mode.
- busy  output  1  high while iterating (BUSY state).

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, counter=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture |a|, |b| (magnitudes if in_signed, raw values otherwise).
  - Also capture neg = in_signed & (a[MSB]^b[MSB]).
  - Clear the accumulator and counter, then go to BUSY.
- BUSY:
  - in_ready=0, busy=1.
  - Each edge: if multiplier LSB=1, add the multiplicand to the accumulator upper half; shift right one bit (standard shift-add, 2*WIDTH+1-bit accumulator); counter++.
  - On the edge where the counter reaches WIDTH-1, write the final result (two's-complement negated if neg) into the product register and go to DONE.
- Latency: operands accepted at edge t0 -> out_valid=1 after edge t0+WIDTH, i.e. exactly WIDTH cycles.
- DONE:
  - out_valid=1 and product stable; in_ready=0.
  - On an edge with out_ready=1, go to IDLE, out_valid=0.
  - product keeps its last value until the next result is written.
- No back-to-back overlap: a new accept requires IDLE, so minimum initiation interval is WIDTH+2 cycles.
- in_valid and a, b, in_signed are ignored outside IDLE. Inputs may change freely once accepted.
- Magnitude of most-negative signed value (-2^(WIDTH-1)) is 2^(WIDTH-1) and fits in WIDTH unsigned bits; the result must be exact.
  - Example: signed min*min = 2^(2*WIDTH-2).
- Zero operands follow the normal WIDTH-cycle path; there is no early-out.
- Reset mid-operation (BUSY or DONE): the operation is discarded and all outputs return to reset values on that edge. No product is emitted.
- out_ready asserted while not in DONE has no effect.

Decomposition:
- Shared package mult_pkg:
  - state typedef (IDLE/BUSY/DONE).
  - Default WIDTH constant.
  - Function abs_val (conditional two's-complement magnitude), reused by future divider blocks.
- One sub-module is natural: mult_seq_dp (accumulator, shift, add, sign-fix datapath), with the FSM/handshake kept in mult_seq. Optional; flat RTL is acceptable.

Test Plan:
- WIDTH=32, unsigned: a=0xFFFFFFFF, b=0xFFFFFFFF -> after 32 cycles out_valid=1, product=0xFFFFFFFE00000001.
- WIDTH=32, signed: a=-3 (0xFFFFFFFD), b=7 -> product=0xFFFFFFFFFFFFFFEB (-21); same operands unsigned -> product=0x00000006FFFFFFEB.
- WIDTH=8, signed: a=0x80, b=0x80 -> product=0x4000. Then a=0x80, b=0x7F -> product=0xC080 (-16256).
- Backpressure: out_ready held 0 for 10 cycles after out_valid -> product and out_valid stay stable, in_ready=0, new in_valid ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-BUSY: assert rst at iteration 5 -> next cycle state IDLE, out_valid=0, product=0. A subsequent 3*5 completes with product=15 after WIDTH cycles.
- Random regression: 10k random a, b, in_signed with random out_ready stalls, at WIDTH=8, 16 and 32 -> product matches the reference model; latency is always WIDTH cycles.
